// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM state type for the vectoring-mode CORDIC.
package cordic_pkg;

    localparam int ANGLE_FRAC = 28;
    localparam logic signed [31:0] PI   = 32'sd843314857;
    localparam logic signed [31:0] PI_2 = 32'sd421657428;
    localparam logic [16:0] INV_K = 17'd39797;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        COMP,
        DONE
    } cordic_vec_state_t;

    // atan(2^-i) in Q4.28
    function automatic logic [31:0] atan_lut(input logic [3:0] i);
        logic [31:0] a;
        case (i)
            4'd0:    a = 32'd210828714;
            4'd1:    a = 32'd124459457;
            4'd2:    a = 32'd65760959;
            4'd3:    a = 32'd33381289;
            4'd4:    a = 32'd16755421;
            4'd5:    a = 32'd8385878;
            4'd6:    a = 32'd4193962;
            4'd7:    a = 32'd2097109;
            4'd8:    a = 32'd1048570;
            4'd9:    a = 32'd524287;
            4'd10:   a = 32'd262143;
            4'd11:   a = 32'd131071;
            4'd12:   a = 32'd65535;
            4'd13:   a = 32'd32767;
            4'd14:   a = 32'd16383;
            default: a = 32'd8191;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x,y) -> magnitude and atan2 phase, one micro-rotation per clock.
// Optional gain compensation stage is enabled by defining GAIN_COMP_EN.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] magnitude,
    output logic [WIDTH-1:0] phase
);

    localparam int XW = WIDTH + 2;
    localparam logic [3:0] LAST = 4'(ITER - 1);
    localparam logic signed [XW-1:0] MAG_MAX = XW'({(WIDTH-1){1'b1}});
    localparam logic signed [WIDTH-1:0] PI_W = WIDTH'(PI);
    localparam logic signed [WIDTH-1:0] PI_2_W = WIDTH'(PI_2);
    localparam logic signed [WIDTH-1:0] NEG_PI_LIM = -PI_W + WIDTH'(1);

    cordic_vec_state_t state, state_next;

    logic signed [XW-1:0]    x_q, y_q, x_ext, y_ext, x_shift, y_shift;
    logic signed [WIDTH-1:0] z_q, atan_i;
    logic [3:0]              iter;
    logic                    zero_q;
    logic                    accept;

    assign x_ext   = {{2{x_in[WIDTH-1]}}, x_in};
    assign y_ext   = {{2{y_in[WIDTH-1]}}, y_in};
    assign x_shift = x_q >>> iter;
    assign y_shift = y_q >>> iter;
    assign atan_i  = WIDTH'(atan_lut(iter));

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

`ifdef GAIN_COMP_EN
    localparam int PW = XW + 17;
    localparam logic signed [PW-1:0] ROUND = PW'(32768);
    logic signed [PW-1:0] x_wide;
    logic signed [XW-1:0] x_comp;
    always_comb begin
        x_wide = PW'(x_q);
        x_comp = XW'((x_wide * $signed({1'b0, INV_K}) + ROUND) >>> 16);
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept) state_next = ROTATE;
            ROTATE: if (iter == LAST) begin
`ifdef GAIN_COMP_EN
                state_next = COMP;
`else
                state_next = DONE;
`endif
            end
            COMP:   state_next = DONE;
            DONE:   if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Quadrant pre-rotation brings the vector into the right half-plane so the
    // micro-rotations only have to cover +/-PI/2; negation is done at XW bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            iter   <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    iter   <= '0;
                    zero_q <= (x_in == '0) && (y_in == '0);
                    if (!x_ext[XW-1]) begin
                        x_q <= x_ext;
                        y_q <= y_ext;
                        z_q <= '0;
                    end else if (!y_ext[XW-1]) begin
                        x_q <= y_ext;
                        y_q <= -x_ext;
                        z_q <= PI_2_W;
                    end else begin
                        x_q <= -y_ext;
                        y_q <= x_ext;
                        z_q <= -PI_2_W;
                    end
                end
                ROTATE: begin
                    iter <= iter + 4'd1;
                    if (!y_q[XW-1]) begin
                        x_q <= x_q + y_shift;
                        y_q <= y_q - x_shift;
                        z_q <= z_q + atan_i;
                    end else begin
                        x_q <= x_q - y_shift;
                        y_q <= y_q + x_shift;
                        z_q <= z_q - atan_i;
                    end
                end
`ifdef GAIN_COMP_EN
                COMP: x_q <= x_comp;
`endif
                default: ;
            endcase
        end
    end

    // Results are driven only in DONE; phase is clamped into (-PI, +PI] so a
    // negative-x, zero-y input can never report -PI through residual error.
    always_comb begin
        magnitude = '0;
        phase     = '0;
        if (state == DONE && !zero_q) begin
            if (x_q > MAG_MAX)   magnitude = MAG_MAX[WIDTH-1:0];
            else if (x_q[XW-1])  magnitude = '0;
            else                 magnitude = x_q[WIDTH-1:0];
            if (z_q > PI_W)              phase = PI_W;
            else if (z_q < NEG_PI_LIM)   phase = NEG_PI_LIM;
            else                         phase = z_q;
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed table-driven bench for cordic_vectoring; expected magnitudes include
// the CORDIC gain unless GAIN_COMP_EN is defined.
module tb_cordic_vectoring;

    localparam int WIDTH = 32;
    localparam int ITER  = 12;
    localparam real PHASE_TOL = 262144.0;
`ifdef GAIN_COMP_EN
    localparam real GAIN = 1.0;
    localparam int  LAT  = ITER + 1;
`else
    localparam real GAIN = 1.646760;
    localparam int  LAT  = ITER;
`endif

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        longint             mag;
        logic signed [31:0] ph;
    } vec_t;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] magnitude;
    logic [WIDTH-1:0] phase;

    int num_checks = 0;
    int num_errors = 0;
    vec_t vecs [11];

    cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .magnitude (magnitude),
        .phase     (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkExact(input string name, input longint act, input longint exp);
        num_checks++;
        if (act != exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkNear(input string name, input longint act, input real exp, input real tol);
        real d;
        num_checks++;
        d = real'(act) - exp;
        if (d > tol || -d > tol) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0.1f +/- %0.1f", name, act, exp, tol);
        end
    endtask

    task automatic checkOutput(input string name, input longint true_mag, input longint exp_phase);
        real em;
        em = real'(true_mag) * GAIN;
        if (em > 2147483647.0) em = 2147483647.0;
        checkExact({name, " out_valid"}, longint'(out_valid), 1);
        checkNear({name, " magnitude"}, longint'($signed(magnitude)), em, em * 0.001 + 1.0);
        checkNear({name, " phase"}, longint'($signed(phase)), real'(exp_phase), PHASE_TOL);
    endtask

    // Waits for in_ready, performs the accept handshake and then counts the
    // edges until out_valid; optionally keeps in_valid asserted with junk data
    // while the block is busy to show it is ignored.
    task automatic applyStimulus(input string name, input logic [31:0] x, input logic [31:0] y,
                                 input bit spam);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        checkExact({name, " in_ready before accept"}, longint'(in_ready), 1);
        in_valid = 1'b1;
        x_in = x;
        y_in = y;
        @(posedge clock); #1;
        in_valid = spam;
        x_in = ~x;
        y_in = x;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        in_valid = 1'b0;
        checkExact({name, " latency"}, n, LAT);
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'sd1048576,  32'sd0,        64'd1048576,    32'sd0};
        vecs[1]  = '{32'sd0,        32'sd1048576,  64'd1048576,    32'sd421657428};
        vecs[2]  = '{-32'sd1048576, 32'sd0,        64'd1048576,    32'sd843314857};
        vecs[3]  = '{-32'sd1048576, -32'sd1048576, 64'd1482910,    -32'sd632486143};
        vecs[4]  = '{32'sd1048576,  32'sd1048576,  64'd1482910,    32'sd210828714};
        vecs[5]  = '{32'sd0,        -32'sd1048576, 64'd1048576,    -32'sd421657428};
        vecs[6]  = '{32'sd786432,   32'sd1048576,  64'd1310720,    32'sd248918914};
        vecs[7]  = '{32'sd786432,   -32'sd1048576, 64'd1310720,    -32'sd248918914};
        vecs[8]  = '{32'h80000000,  32'sd0,        64'd2147483648, 32'sd843314857};
        vecs[9]  = '{32'h80000000,  32'h80000000,  64'd3037000500, -32'sd632486143};
        vecs[10] = '{-32'sd786432,  32'sd1048576,  64'd1310720,    32'sd594395943};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x_in = '0;
        y_in = '0;
        repeat (2) @(posedge clock);
        #1;
        checkExact("reset in_ready", longint'(in_ready), 0);
        checkExact("reset out_valid", longint'(out_valid), 0);
        checkExact("reset magnitude", longint'(magnitude), 0);
        checkExact("reset phase", longint'(phase), 0);
        reset = 1'b0;
        #1;
        checkExact("post-reset in_ready", longint'(in_ready), 1);

        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            applyStimulus(nm, vecs[i].x, vecs[i].y, 1'b0);
            checkOutput(nm, vecs[i].mag, longint'(vecs[i].ph));
            if (vecs[i].x < 0 && vecs[i].y == 0)
                checkExact({nm, " phase positive"}, longint'($signed(phase) > 0), 1);
            releaseResult();
        end

        applyStimulus("zero", 32'd0, 32'd0, 1'b0);
        checkExact("zero magnitude", longint'(magnitude), 0);
        checkExact("zero phase", longint'(phase), 0);
        releaseResult();

        // Result held under back-pressure, busy-time in_valid ignored, then back-to-back.
        applyStimulus("hold", 32'd1048576, 32'd1048576, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            checkOutput($sformatf("hold cycle%0d", c), 1482910, 210828714);
            checkExact($sformatf("hold cycle%0d in_ready", c), longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        checkExact("handshake in_ready", longint'(in_ready), 1);
        checkExact("handshake out_valid", longint'(out_valid), 0);
        applyStimulus("b2b", -32'sd1048576, -32'sd1048576, 1'b0);
        checkOutput("b2b", 1482910, -632486143);
        releaseResult();

        // Reset during iteration 5 aborts the transaction.
        while (!in_ready) begin
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        x_in = 32'd1048576;
        y_in = 32'd0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checkExact("abort out_valid", longint'(out_valid), 0);
        checkExact("abort in_ready", longint'(in_ready), 0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        checkExact("abort release in_ready", longint'(in_ready), 1);
        checkExact("abort release out_valid", longint'(out_valid), 0);
        applyStimulus("after abort", 32'd786432, 32'd1048576, 1'b0);
        checkOutput("after abort", 1310720, 248918914);

        // Reset while a result is pending drops out_valid without waiting for a clock edge.
        #2 reset = 1'b1;
        #1;
        checkExact("done abort out_valid", longint'(out_valid), 0);
        checkExact("done abort magnitude", longint'(magnitude), 0);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        applyStimulus("final", 32'd0, 32'd1048576, 1'b0);
        checkOutput("final", 1048576, 421657428);
        releaseResult();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
